// File: rtl/seg7_scan_reader.sv
// Snoops a multiplexed 7-segment bus and recovers the BCD digit shown at each position.
// Optional macro SEG7_ALT_GLYPH_EN accepts tail-less 6/9 and the 7 drawn with segment f.
module seg7_scan_reader #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:7]          seg,
    input  logic [NDIG-1:0]     an,
    output logic [4*NDIG-1:0]   bcd,
    output logic [NDIG-1:0]     vld,
    output logic                err,
    output logic                frame
);

    // state  | meaning
    // WAIT   | registered digit select is zero or multi-hot, counter idle
    // SETTLE | one-hot sample, counting repeats; capture fires on the edge leaving for HOLD
    // HOLD   | sample already captured, waiting for it to change
    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    // cnt counts repeats after the first sample, so STABLE samples means cnt reaches STABLE-1
    localparam logic [3:0] CNT_LAST = 4'(STABLE - 2);

    logic [NDIG-1:0]   an_q, an_d, an_prev_q, an_prev_d;
    logic [1:7]        seg_q, seg_d, seg_prev_q, seg_prev_d;
    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [4*NDIG-1:0] bcd_q, bcd_d;
    logic [NDIG-1:0]   vld_q, vld_d;
    logic [NDIG-1:0]   seen_q, seen_d;
    logic              err_q, err_d;
    logic              frame_q, frame_d;

    logic              onehot;
    logic              changed;
    logic              capture;
    logic [4:0]        dec;
    logic [NDIG-1:0]   seen_upd;

    // Returns {legal, value}
    function automatic logic [4:0] decode(input logic [1:7] g);
        logic [4:0] r;
        r = 5'b0_0000;
        case (g)
            7'b1111110: r = {1'b1, 4'd0};
            7'b0110000: r = {1'b1, 4'd1};
            7'b1101101: r = {1'b1, 4'd2};
            7'b1111001: r = {1'b1, 4'd3};
            7'b0110011: r = {1'b1, 4'd4};
            7'b1011011: r = {1'b1, 4'd5};
            7'b1011111: r = {1'b1, 4'd6};
            7'b1110000: r = {1'b1, 4'd7};
            7'b1111111: r = {1'b1, 4'd8};
            7'b1111011: r = {1'b1, 4'd9};
`ifdef SEG7_ALT_GLYPH_EN
            7'b0011111: r = {1'b1, 4'd6};
            7'b1110011: r = {1'b1, 4'd9};
            7'b1110010: r = {1'b1, 4'd7};
`endif
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    assign onehot  = (an_q != '0) && ((an_q & (an_q - NDIG'(1))) == '0);
    assign changed = {an_q, seg_q} != {an_prev_q, seg_prev_q};

    always_comb begin
        an_d       = an;
        seg_d      = seg;
        an_prev_d  = an_q;
        seg_prev_d = seg_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        vld_d      = vld_q;
        seen_d     = seen_q;
        err_d      = 1'b0;
        frame_d    = 1'b0;
        capture    = 1'b0;
        dec        = 5'b0_0000;
        seen_upd   = seen_q;

        if (!onehot) begin
            state_d = ST_WAIT;
            cnt_d   = 4'd0;
        end else if (changed) begin
            state_d = ST_SETTLE;
            cnt_d   = 4'd0;
        end else if (state_q == ST_SETTLE) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
                capture = 1'b1;
                state_d = ST_HOLD;
            end
        end

        if (capture) begin
            dec = decode(seg_q);
            for (int i = 0; i < NDIG; i++) begin
                if (an_q[i]) begin
                    if (dec[4]) begin
                        bcd_d[4*i +: 4] = dec[3:0];
                        vld_d[i]        = 1'b1;
                    end else if (seg_q == 7'b0000000) begin
                        bcd_d[4*i +: 4] = 4'hF;
                        vld_d[i]        = 1'b0;
                    end else begin
                        vld_d[i] = 1'b0;
                        err_d    = 1'b1;
                    end
                end
            end
            // The completing capture starts the next frame with an empty mask
            seen_upd = seen_q | an_q;
            if (&seen_upd) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d = seen_upd;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q       <= '0;
            seg_q      <= '0;
            an_prev_q  <= '0;
            seg_prev_q <= '0;
            state_q    <= ST_WAIT;
            cnt_q      <= 4'd0;
            bcd_q      <= '0;
            vld_q      <= '0;
            seen_q     <= '0;
            err_q      <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            an_q       <= an_d;
            seg_q      <= seg_d;
            an_prev_q  <= an_prev_d;
            seg_prev_q <= seg_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            vld_q      <= vld_d;
            seen_q     <= seen_d;
            err_q      <= err_d;
            frame_q    <= frame_d;
        end
    end

    assign bcd   = bcd_q;
    assign vld   = vld_q;
    assign err   = err_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Scoreboard bench for seg7_scan_reader: held bus patterns predict capture events,
// a negedge monitor pops them and compares every output every cycle.
module tb_seg7_scan_reader;
    localparam int NDIG   = 4;
    localparam int STABLE = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:7]        seg;
    logic [NDIG-1:0]   an;
    logic [4*NDIG-1:0] bcd;
    logic [NDIG-1:0]   vld;
    logic              err;
    logic              frame;

    seg7_scan_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk(clk), .reset(reset), .seg(seg), .an(an),
        .bcd(bcd), .vld(vld), .err(err), .frame(frame)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int                edge_n;
        logic [4*NDIG-1:0] bcd;
        logic [NDIG-1:0]   vld;
        logic              err;
        logic              frame;
    } exp_t;

    exp_t exp_q[$];

    logic [4*NDIG-1:0] m_bcd  = '0;
    logic [NDIG-1:0]   m_vld  = '0;
    logic [NDIG-1:0]   m_seen = '0;
    logic [NDIG-1:0]   prev_an  = '0;
    logic [1:7]        prev_seg = '0;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_on  = 1'b1;

    logic [1:7] glyph_tab [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    logic [1:7] alt_tab [0:2]   = '{7'b0011111, 7'b1110011, 7'b1110010};

    // -1 illegal, -2 blank, otherwise the digit
    function automatic int ref_decode(input logic [1:7] g);
        for (int v = 0; v < 10; v++)
            if (glyph_tab[v] == g) return v;
`ifdef SEG7_ALT_GLYPH_EN
        if (g == alt_tab[0]) return 6;
        if (g == alt_tab[1]) return 9;
        if (g == alt_tab[2]) return 7;
`endif
        if (g == 7'b0000000) return -2;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_cnt, act, req);
        end
    endtask

    task automatic push_capture(input logic [NDIG-1:0] a, input logic [1:7] g, input int at_edge);
        exp_t r;
        int   idx;
        int   v;
        idx = 0;
        for (int i = 0; i < NDIG; i++) if (a[i]) idx = i;
        v = ref_decode(g);
        r.err = 1'b0;
        if (v >= 0) begin
            m_bcd[4*idx +: 4] = v[3:0];
            m_vld[idx]        = 1'b1;
        end else if (v == -2) begin
            m_bcd[4*idx +: 4] = 4'hF;
            m_vld[idx]        = 1'b0;
        end else begin
            m_vld[idx] = 1'b0;
            r.err      = 1'b1;
        end
        m_seen[idx] = 1'b1;
        r.frame = &m_seen;
        if (r.frame) m_seen = '0;
        r.edge_n = at_edge;
        r.bcd    = m_bcd;
        r.vld    = m_vld;
        exp_q.push_back(r);
    endtask

    // Called just after an edge; pattern is sampled from the next edge for h edges
    task automatic hold(input logic [NDIG-1:0] a, input logic [1:7] g, input int h);
        if ($countones(a) == 1 && h >= STABLE)
            push_capture(a, g, edge_cnt + 1 + STABLE);
        an  = a;
        seg = g;
        repeat (h) @(posedge clk);
        #1;
        prev_an  = a;
        prev_seg = g;
    endtask

    task automatic do_reset();
        exp_t r;
        reset  = 1'b1;
        m_bcd  = '0;
        m_vld  = '0;
        m_seen = '0;
        r.edge_n = edge_cnt;
        r.bcd    = '0;
        r.vld    = '0;
        r.err    = 1'b0;
        r.frame  = 1'b0;
        exp_q.push_back(r);
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        prev_an  = '0;
        prev_seg = '0;
    endtask

    logic [4*NDIG-1:0] cur_bcd = '0;
    logic [NDIG-1:0]   cur_vld = '0;
    logic              e_err;
    logic              e_frame;
    exp_t              mr;

    always @(negedge clk) begin
        if (mon_on) begin
            e_err   = 1'b0;
            e_frame = 1'b0;
            while (exp_q.size() > 0 && exp_q[0].edge_n <= edge_cnt) begin
                mr = exp_q.pop_front();
                if (mr.edge_n < edge_cnt) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL event_late: due edge %0d, popped at edge %0d", mr.edge_n, edge_cnt);
                end
                cur_bcd = mr.bcd;
                cur_vld = mr.vld;
                e_err   = mr.err;
                e_frame = mr.frame;
            end
            chk("bcd",   32'(bcd),   32'(cur_bcd));
            chk("vld",   32'(vld),   32'(cur_vld));
            chk("err",   32'(err),   32'(e_err));
            chk("frame", 32'(frame), 32'(e_frame));
        end
    end

    initial begin
        reset = 1'b1;
        an    = '0;
        seg   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        hold(4'b0000, 7'b0000000, 20);

        hold(4'b0001, 7'b1011011, 8);
        hold(4'b0010, 7'b1111001, 8);
        hold(4'b0100, 7'b0110000, 8);
        hold(4'b1000, 7'b1111111, 8);
        chk("scan_bcd", 32'(bcd), 32'h8135);
        chk("scan_vld", 32'(vld), 32'hF);

        hold(4'b0001, 7'b1101101, 2);
        hold(4'b0001, 7'b1110000, 3);
        hold(4'b0100, 7'b0000001, 5);
        hold(4'b0010, 7'b0000000, 4);
        hold(4'b0011, 7'b1111111, 10);
        hold(4'b0001, 7'b1111110, 2);
        do_reset();
        hold(4'b0001, 7'b1111110, 3);
        hold(4'b0000, 7'b0000000, 2);
        hold(4'b0001, 7'b0011111, 4);

        for (int n = 0; n < 400; n++) begin
            logic [NDIG-1:0] a;
            logic [1:7]      g;
            int              h;
            int              r;
            bit              rst_after;
            r = $urandom_range(0, 99);
            if (r < 75)      a = NDIG'(1) << $urandom_range(0, NDIG - 1);
            else if (r < 85) a = '0;
            else             a = NDIG'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            if (r < 6)       g = glyph_tab[$urandom_range(0, 9)];
            else if (r == 6) g = 7'b0000000;
            else if (r == 7) g = alt_tab[$urandom_range(0, 2)];
            else             g = 7'($urandom_range(0, 127));
            if ($countones(a) == 1 && a == prev_an && g == prev_seg)
                g = g ^ 7'b0000001;
            h = $urandom_range(1, STABLE + 4);
            rst_after = ($urandom_range(0, 99) < 5);
            // a capture due on the edge after the hold would race the reset
            if (rst_after && h == STABLE) h++;
            hold(a, g, h);
            if (rst_after) do_reset();
        end

        hold(4'b0000, 7'b0000000, STABLE + 3);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
